sram_psum_acc: RTL
==================

// Module: sram_psum_acc
// PURPOSE
//  Parametrised single-port output SRAM that stores LANES signed partial sums per word.
//  Supports plain read, lane-masked write, and lane-masked read-modify-write accumulate
//  (mem += D) with optional saturation, plus a bulk-clear sequencer.
//  Sits after the array's output FIFO, where psums from successive tiles are summed in place.
// PARAMETERS
//  LANES   8     psum lanes per word
//  LANE_W  16    bits per lane, two's complement
//  DEPTH   2048  words; AW = $clog2(DEPTH) is a derived localparam
//  SAT     1     1 = saturate accumulate to signed LANE_W range, 0 = wrap modulo 2^LANE_W
// PORTS
//  CLK       in   1             clock, all state on rising edge
//  reset_n   in   1             asynchronous active-low reset
//  CEN       in   1             chip enable, active low
//  WEN       in   1             write enable, active low (1 = read)
//  ACC       in   1             with WEN=0: 1 = accumulate, 0 = plain write
//  LM        in   LANES         lane enable for write/accumulate, 1 = lane affected
//  A         in   AW            word address
//  D         in   LANES*LANE_W  write data / addend; lane i = D[i*LANE_W +: LANE_W]
//  clr_start in   1             one-cycle pulse: zero the whole array
//  Q         out  LANES*LANE_W  registered read data
//  q_valid   out  1             high for one cycle when Q carries new read data
//  busy      out  1             clear sweep in progress; requests ignored
// BEHAVIOUR
//  Reset (async, reset_n=0): Q=0, q_valid=0, busy=0, FSM=IDLE, acc stage invalid.
//    Memory contents are not reset.
//  Request accepted at an edge when CEN=0 and busy=0. With busy=1, CEN/WEN/ACC are ignored.
//  Read (WEN=1): Q <= mem[A] at the accepting edge; q_valid=1 the following cycle only.
//    Q holds its value between reads. LM is ignored.
//  Write (WEN=0, ACC=0): for each lane with LM=1, mem[A].lane <= D.lane at the accepting edge.
//  Accumulate (WEN=0, ACC=1): 2-stage operation.
//    Accepting edge: registers acc_a, acc_d, acc_lm; sets acc_v.
//    Next cycle: sum.lane = mem[acc_a].lane + acc_d.lane for lanes with acc_lm=1.
//    The following edge writes sum to memory. Unmasked lanes are unchanged. acc_v clears
//    unless a new accumulate is accepted.
//  Arithmetic: add at LANE_W+1 bits.
//    SAT=1: clamp to [-2^(LANE_W-1), 2^(LANE_W-1)-1].
//    SAT=0: keep the low LANE_W bits.
//  Hazards, where the new request arrives in the cycle acc_v=1 and A==acc_a:
//    - read: Q <= sum for enabled lanes, mem value for other lanes (forwarding).
//    - plain write: on lanes with LM=1 the plain write wins; other acc lanes take sum.
//    - accumulate: no forwarding needed; it reads mem one cycle later, after write-back.
//  Back-to-back accumulates sustain one accumulate per cycle.
//  Clear FSM:
//    - IDLE -> CLEAR on clr_start=1 (clr_start is ignored in CLEAR).
//    - The acc write-back pending at entry completes before the sweep begins.
//    - busy=1 from the edge after clr_start.
//    - CLEAR writes 0 to address ctr=0..DEPTH-1, one word per cycle (DEPTH cycles).
//    - busy drops and FSM returns to IDLE after the write to DEPTH-1.
//    - clr_start together with a request in the same cycle: the request is accepted,
//      then the clear starts.
//    - reset_n low mid-clear: FSM=IDLE, busy=0; words not yet swept keep old contents.
//  Address A >= DEPTH (non-power-of-2 DEPTH): the write is dropped and the read returns 0.
// TESTING
//  1. Write A=5 D=lanes 1..8, LM=all, then read A=5: Q=1..8, q_valid high exactly one
//     cycle later.
//  2. SAT=1: lane0=0x7FF0 acc +0x0020 -> 0x7FFF; lane1=0x8000 acc -1 -> 0x8000.
//     SAT=0: the same stimulus gives 0x8010 and 0x7FFF.
//  3. Acc A=9 (+3 onto 10), read A=9 next cycle: Q lane=13 (forwarded). A second read
//     gives 13 from memory.
//  4. Acc A=9 LM=0xFF; next cycle plain write A=9 LM=0x0F D=0: lanes 0-3=0, lanes 4-7=sum.
//  5. 4 back-to-back accumulates of +1 to A=2 from 0 -> read returns 4 in every lane.
//  6. clr_start: busy high for 2048 cycles; writes during busy are ignored; all reads after
//     return 0. Reset at sweep cycle 100: busy=0 at once, address 1000 keeps old data.

Source files
------------

// File: rtl/sram_psum_acc_if.sv
// rtl/sram_psum_acc_if.sv - request/response bundle of the psum accumulator SRAM
//
// Groups the SRAM request side (CEN, WEN, ACC, LM, A, D, clr_start) and the
// response side (Q, q_valid, busy). The master drives requests, and the slave
// is the SRAM.
//   CEN       chip enable, active low
//   WEN       write enable, active low (1 = read)
//   ACC       with WEN=0: 1 = accumulate, 0 = plain write
//   LM        per-lane enable for write/accumulate
//   A         word address
//   D         write data / addend, lane i = D[i*LANE_W +: LANE_W]
//   clr_start one-cycle pulse that starts the bulk clear
//   Q         registered read data
//   q_valid   Q carries new read data this cycle
//   busy      clear sweep in progress, requests ignored
interface sram_psum_acc_if #(
  parameter int LANES  = 8,
  parameter int LANE_W = 16,
  parameter int AW     = 11
);
  logic                    CEN;
  logic                    WEN;
  logic                    ACC;
  logic [LANES-1:0]        LM;
  logic [AW-1:0]           A;
  logic [LANES*LANE_W-1:0] D;
  logic                    clr_start;
  logic [LANES*LANE_W-1:0] Q;
  logic                    q_valid;
  logic                    busy;

  modport master (
    output CEN, WEN, ACC, LM, A, D, clr_start,
    input  Q, q_valid, busy
  );

  modport slave (
    input  CEN, WEN, ACC, LM, A, D, clr_start,
    output Q, q_valid, busy
  );
endinterface

// File: rtl/sram_psum_acc.sv
// rtl/sram_psum_acc.sv - single-port psum SRAM with lane-masked write/accumulate and bulk clear
//
// Stores LANES signed partial sums per word. It supports a plain read, a
// lane-masked write, and a lane-masked read-modify-write accumulate
// (mem += D). The accumulate saturates when SAT=1 and wraps when SAT=0. A
// sequencer zeroes the whole array on request.
//   CLK      clock, all state on the rising edge
//   reset_n  asynchronous active-low reset (memory contents are kept)
//   bus      slave side of sram_psum_acc_if (request in, Q/q_valid/busy out)
module sram_psum_acc #(
  parameter int LANES  = 8,
  parameter int LANE_W = 16,
  parameter int DEPTH  = 2048,
  parameter bit SAT    = 1'b1
) (
  input  logic            CLK,
  input  logic            reset_n,
  sram_psum_acc_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = LANES * LANE_W;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state;
  logic [WW-1:0]   mem [DEPTH];
  logic            acc_v;
  logic [AW-1:0]   acc_a;
  logic [WW-1:0]   acc_d;
  logic [LANES-1:0] acc_lm;
  logic [AW-1:0]   ctr;
  logic [WW-1:0]   q_r;
  logic            q_valid_r;
  logic            busy_r;

  logic            accept, do_read, do_write, do_acc;
  logic            a_ok, acc_ok;
  logic [WW-1:0]   acc_base, sum_word, rd_word;

  // Add at LANE_W+1 bits. With SAT the sum clamps when the top two bits differ.
  function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] x,
                                                 input logic [LANE_W-1:0] y);
    logic [LANE_W:0] s;
    s = {x[LANE_W-1], x} + {y[LANE_W-1], y};
    if (SAT && (s[LANE_W] != s[LANE_W-1]))
      return s[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    return s[LANE_W-1:0];
  endfunction

  assign accept   = !bus.CEN && !busy_r;
  assign do_read  = accept && bus.WEN;
  assign do_write = accept && !bus.WEN && !bus.ACC;
  assign do_acc   = accept && !bus.WEN && bus.ACC;
  assign a_ok     = {1'b0, bus.A} < DEPTH_W;
  assign acc_ok   = {1'b0, acc_a} < DEPTH_W;

  // Second accumulate stage: unmasked lanes pass the stored value through,
  // so sum_word is the complete word to write back.
  always_comb begin
    acc_base = acc_ok ? mem[acc_a] : '0;
    sum_word = acc_base;
    for (int i = 0; i < LANES; i++) begin
      if (acc_lm[i])
        sum_word[i*LANE_W +: LANE_W] = lane_add(acc_base[i*LANE_W +: LANE_W],
                                                acc_d[i*LANE_W +: LANE_W]);
    end
  end

  // A read of the word whose write-back is pending takes the merged sum.
  always_comb begin
    rd_word = a_ok ? mem[bus.A] : '0;
    if (acc_v && (acc_a == bus.A))
      rd_word = sum_word;
  end

  // Array writes happen in this order: accumulate write-back, then the plain
  // write (its enabled lanes win on a same-address hazard), then the clear.
  always_ff @(posedge CLK) begin
    if (acc_v && acc_ok)
      mem[acc_a] <= sum_word;
    if (do_write && a_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.LM[i])
          mem[bus.A][i*LANE_W +: LANE_W] <= bus.D[i*LANE_W +: LANE_W];
      end
    end
    if (state == CLEAR)
      mem[ctr] <= '0;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy_r    <= 1'b0;
      ctr       <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      acc_v     <= 1'b0;
      acc_a     <= '0;
      acc_d     <= '0;
      acc_lm    <= '0;
    end else begin
      q_valid_r <= do_read;
      if (do_read)
        q_r <= rd_word;
      acc_v <= do_acc;
      if (do_acc) begin
        acc_a  <= bus.A;
        acc_d  <= bus.D;
        acc_lm <= bus.LM;
      end
      case (state)
        IDLE: begin
          if (bus.clr_start) begin
            state  <= CLEAR;
            busy_r <= 1'b1;
            ctr    <= '0;
          end
        end
        CLEAR: begin
          ctr <= ctr + 1'b1;
          if (ctr == LAST) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.busy    = busy_r;
endmodule
